// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM-stage load/store unit. Byte/half/word accesses on an internal
// little-endian data memory with a fixed multi-cycle access latency. Stalls upstream
// until the access completes; faults on misaligned or illegal accesses.
module data_mem_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] opdata,
    output logic        mem_stall,
    output logic        mem_fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(LATENCY - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          misaligned;
    logic          illegal;
    logic          req;
    logic          complete;
    logic          stall_raw;
    logic          wr_en;
    logic          rd_en;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic [31:0]   rdata;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ext;

    // Upper address bits deliberately ignored: addresses wrap modulo memory size.
    logic          unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    assign widx  = addr[AW+1:2];
    assign rdata = mem_q[widx];

    // Fault decode: MemWrite wins, so a store's funct3 rules apply when both are high.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (MemWrite) begin
            case (funct3)
                3'd0:    misaligned = 1'b0;
                3'd1:    misaligned = addr[0];
                3'd2:    misaligned = |addr[1:0];
                default: illegal    = 1'b1;
            endcase
        end else if (MemRead) begin
            case (funct3)
                3'd0, 3'd4: misaligned = 1'b0;
                3'd1, 3'd5: misaligned = addr[0];
                3'd2:       misaligned = |addr[1:0];
                default:    illegal    = 1'b1;
            endcase
        end
    end

    assign mem_fault = (MemRead | MemWrite) & (misaligned | illegal);
    assign req       = (MemRead | MemWrite) & ~mem_fault;

    // Access sequencing: LATENCY cycles per request, stall on all but the last.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        complete  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (LATENCY > 1) begin
                        stall_raw = 1'b1;
                        state_d   = StWait;
                        cnt_d     = CW'(1);
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == LastCnt) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                    cnt_d    = '0;
                end else begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and latency counter; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write/read qualifiers use the live request signals at the completion cycle.
    assign wr_en     = complete & MemWrite & ~mem_fault & ~reset;
    assign rd_en     = complete & MemRead & ~MemWrite & ~mem_fault & ~reset;
    assign mem_stall = stall_raw & ~reset;

    // Byte-lane enables and replicated store data.
    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        case (funct3[1:0])
            2'd0: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'd1: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // Synchronous byte-masked write port; memory contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // Load extraction and sign/zero extension.
    always_comb begin
        rbyte = rdata[{addr[1:0], 3'b000} +: 8];
        rhalf = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'd0:    ext = {{24{rbyte[7]}}, rbyte};
            3'd4:    ext = {24'b0, rbyte};
            3'd1:    ext = {{16{rhalf[15]}}, rhalf};
            3'd5:    ext = {16'b0, rhalf};
            3'd2:    ext = rdata;
            default: ext = 32'b0;
        endcase
    end

    assign opdata = rd_en ? ext : 32'b0;

endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: three instances (LATENCY 1, 3, 4) checked every cycle
// against a byte-addressed memory model, plus directed literal expectations.
module tb_data_mem_stage;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr [NDUT];
    logic        mw [NDUT];
    logic [2:0]  f3 [NDUT];
    logic [31:0] ad [NDUT];
    logic [31:0] wd [NDUT];
    logic [31:0] od [NDUT];
    logic        st [NDUT];
    logic        ft [NDUT];

    int n_chk  = 0;
    int n_fail = 0;

    // Byte-level model memory per instance, with known flags.
    logic [7:0] mb [NDUT][4096];
    bit         kb [NDUT][4096];
    int         el [NDUT];

    logic [31:0] d;
    int          s;
    logic        fl;

    always #5 clk = ~clk;

    data_mem_stage #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .funct3(f3[0]),
        .addr(ad[0]), .wdata(wd[0]), .opdata(od[0]), .mem_stall(st[0]), .mem_fault(ft[0])
    );
    data_mem_stage #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .funct3(f3[1]),
        .addr(ad[1]), .wdata(wd[1]), .opdata(od[1]), .mem_stall(st[1]), .mem_fault(ft[1])
    );
    data_mem_stage #(.DEPTH_WORDS(1024), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset), .MemRead(mr[2]), .MemWrite(mw[2]), .funct3(f3[2]),
        .addr(ad[2]), .wdata(wd[2]), .opdata(od[2]), .mem_stall(st[2]), .mem_fault(ft[2])
    );

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int size_of(input logic [2:0] f);
        case (f[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit fault_of(input logic rd, input logic wr, input logic [2:0] f,
                                    input logic [31:0] a);
        bit legal;
        int sz;
        if (!(rd || wr)) return 1'b0;
        if (wr) legal = (f <= 3'd2);
        else    legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
        if (!legal) return 1'b1;
        sz = size_of(f);
        return (a & 32'(sz - 1)) != 32'd0;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%08h required 0x%08h", name, k, got, exp);
        end
    endtask

    task automatic store_model(input int k, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] w);
        int n;
        int base;
        n    = size_of(f);
        base = int'(a % 32'd4096);
        for (int i = 0; i < n; i++) begin
            mb[k][(base + i) % 4096] = 8'((w >> (8 * i)) & 32'hFF);
            kb[k][(base + i) % 4096] = 1'b1;
        end
    endtask

    task automatic load_model(input int k, input logic [2:0] f, input logic [31:0] a,
                              output logic [31:0] v, output bit known);
        int n;
        int base;
        logic [31:0] b;
        n     = size_of(f);
        base  = int'(a % 32'd4096);
        v     = 32'd0;
        known = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!kb[k][(base + i) % 4096]) known = 1'b0;
            b = 32'(mb[k][(base + i) % 4096]);
            v = v | (b << (8 * i));
        end
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    endtask

    // Per-cycle comparison against the model; model advances for the coming edge.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            bit          flt;
            bit          act;
            bit          last;
            bit          known;
            int          pos;
            logic [31:0] exp_op;
            flt = fault_of(mr[k], mw[k], f3[k], ad[k]);
            chk("mem_fault", k, 32'(ft[k]), 32'(flt));
            if (reset) begin
                chk("stall_in_reset", k, 32'(st[k]), 32'd0);
                chk("opdata_in_reset", k, od[k], 32'd0);
                el[k] = 0;
            end else begin
                act    = (el[k] > 0) || ((mr[k] || mw[k]) && !flt);
                pos    = el[k] + 1;
                last   = act && (pos == lat_of(k));
                exp_op = 32'd0;
                known  = 1'b1;
                if (last && mr[k] && !mw[k] && !flt) begin
                    load_model(k, f3[k], ad[k], exp_op, known);
                end
                chk("mem_stall", k, 32'(st[k]), 32'(act && (pos < lat_of(k))));
                if (known) chk("opdata", k, od[k], exp_op);
                if (last) begin
                    if (mw[k] && !flt) store_model(k, f3[k], ad[k], wd[k]);
                    el[k] = 0;
                end else if (act) begin
                    el[k] = pos;
                end
            end
        end
    end

    // One access: drive at posedge+1, wait for the non-stalled cycle, release.
    task automatic acc(input int k, input logic rd, input logic wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] w,
                       output logic [31:0] data, output int stalls, output logic flt);
        bit done;
        done   = 1'b0;
        mr[k]  = rd;
        mw[k]  = wr;
        f3[k]  = f;
        ad[k]  = a;
        wd[k]  = w;
        stalls = 0;
        data   = 32'd0;
        flt    = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (st[k] !== 1'b0) begin
                stalls++;
            end else begin
                done = 1'b1;
                data = od[k];
                flt  = ft[k];
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout dut%0d: got stall 1 for 12 cycles required completion", k);
        end
        @(posedge clk);
        #1;
        mr[k] = 1'b0;
        mw[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          r;
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            mr[k] = 1'b0;
            mw[k] = 1'b0;
            f3[k] = 3'd0;
            ad[k] = 32'd0;
            wd[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_stall", k, 32'(st[k]), 32'd0);
            chk("reset_opdata", k, od[k], 32'd0);
            chk("reset_fault", k, 32'(ft[k]), 32'd0);
        end
        reset = 1'b0;

        // LATENCY=1: store then load, never stalls.
        acc(0, 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, d, s, fl);
        chk("l1_sw_stalls", 0, 32'(s), 32'd0);
        acc(0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, d, s, fl);
        chk("l1_lw_stalls", 0, 32'(s), 32'd0);
        chk("l1_lw_data", 0, d, 32'hDEADBEEF);

        // LATENCY=3: byte store into a known word, signed/unsigned byte loads.
        acc(1, 1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344, d, s, fl);
        chk("l3_sw_stalls", 1, 32'(s), 32'd2);
        acc(1, 1'b0, 1'b1, 3'd0, 32'h13, 32'h00000080, d, s, fl);
        chk("l3_sb_stalls", 1, 32'(s), 32'd2);
        acc(1, 1'b1, 1'b0, 3'd0, 32'h13, 32'h0, d, s, fl);
        chk("l3_lb_stalls", 1, 32'(s), 32'd2);
        chk("l3_lb_data", 1, d, 32'hFFFFFF80);
        acc(1, 1'b1, 1'b0, 3'd4, 32'h13, 32'h0, d, s, fl);
        chk("l3_lbu_data", 1, d, 32'h00000080);
        acc(1, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, d, s, fl);
        chk("l3_lw_merged", 1, d, 32'h80223344);

        // Halfword store to the upper lane, then signed and unsigned halfword loads.
        acc(1, 1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678, d, s, fl);
        acc(1, 1'b0, 1'b1, 3'd1, 32'h22, 32'h0000BEEF, d, s, fl);
        acc(1, 1'b1, 1'b0, 3'd1, 32'h22, 32'h0, d, s, fl);
        chk("l3_lh_data", 1, d, 32'hFFFFBEEF);
        acc(1, 1'b1, 1'b0, 3'd5, 32'h20, 32'h0, d, s, fl);
        chk("l3_lhu_low", 1, d, 32'h00005678);

        // Faults: misaligned LW and SH, illegal load funct3.
        acc(1, 1'b0, 1'b1, 3'd2, 32'h04, 32'hCAFEF00D, d, s, fl);
        acc(1, 1'b1, 1'b0, 3'd2, 32'h06, 32'h0, d, s, fl);
        chk("lw_mis_fault", 1, 32'(fl), 32'd1);
        chk("lw_mis_stalls", 1, 32'(s), 32'd0);
        chk("lw_mis_opdata", 1, d, 32'd0);
        acc(1, 1'b0, 1'b1, 3'd1, 32'h05, 32'h00001111, d, s, fl);
        chk("sh_mis_fault", 1, 32'(fl), 32'd1);
        chk("sh_mis_stalls", 1, 32'(s), 32'd0);
        acc(1, 1'b1, 1'b0, 3'd3, 32'h00, 32'h0, d, s, fl);
        chk("ld_illegal_fault", 1, 32'(fl), 32'd1);
        acc(1, 1'b1, 1'b0, 3'd2, 32'h04, 32'h0, d, s, fl);
        chk("mem_unchanged", 1, d, 32'hCAFEF00D);

        // Both MemRead and MemWrite: behaves as a store.
        acc(1, 1'b1, 1'b1, 3'd2, 32'h00, 32'h00000001, d, s, fl);
        chk("both_opdata", 1, d, 32'd0);
        acc(1, 1'b1, 1'b0, 3'd2, 32'h00, 32'h0, d, s, fl);
        chk("both_written", 1, d, 32'h00000001);

        // Address aliasing past the top of memory.
        acc(1, 1'b0, 1'b1, 3'd2, 32'h00001004, 32'h55667788, d, s, fl);
        acc(1, 1'b1, 1'b0, 3'd2, 32'h00000004, 32'h0, d, s, fl);
        chk("alias_word1", 1, d, 32'h55667788);

        // LATENCY=4: reset during the third cycle aborts the store.
        acc(2, 1'b0, 1'b1, 3'd2, 32'h40, 32'h0BADCAFE, d, s, fl);
        chk("l4_sw_stalls", 2, 32'(s), 32'd3);
        mr[2] = 1'b0;
        mw[2] = 1'b1;
        f3[2] = 3'd2;
        ad[2] = 32'h40;
        wd[2] = 32'hAAAA5555;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("l4_stall_pre_rst", 2, 32'(st[2]), 32'd1);
        reset = 1'b1;
        #1;
        chk("l4_stall_on_rst", 2, 32'(st[2]), 32'd0);
        mw[2] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        acc(2, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0, d, s, fl);
        chk("l4_aborted_store", 2, d, 32'h0BADCAFE);
        chk("l4_lw_stalls", 2, 32'(s), 32'd3);

        // Randomised traffic on each instance over words 0..15 with random aliasing.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 16; i++) begin
                acc(k, 1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, d, s, fl);
            end
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 9);
                a = $urandom & 32'hFFFF_F03F;
                f = 3'($urandom_range(0, 7));
                if (r == 9) begin
                    @(posedge clk);
                    #1;
                end else begin
                    acc(k, (r < 4) || (r == 8), r >= 4, f, a, $urandom, d, s, fl);
                end
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
